axil_read_ctrl_slave: RTL and testbench

//  AXI4-Lite slave-side read controller: accepts read-address (AR) handshakes, decodes
//  the address, reads a word from the local register bank and drives the read-data (R)

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil_read_ctrl_slave_if.sv | 26 ++
 rtl/axil_rd_addr_decode.sv | 17 +
 rtl/axil_read_ctrl_slave.sv | 122 ++++++++++++
 tb/tb_axil_read_ctrl_slave.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite response codes, read FSM states and data width
package axil_pkg;

    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        RESP
    } rd_state_t;

endpackage

// File: rtl/axil_read_ctrl_slave_if.sv
// rtl/axil_read_ctrl_slave_if.sv - AXI4-Lite AR/R channel bundle with master/slave views
interface axil_read_ctrl_slave_if #(
    parameter int ADDR_W = 12
);
    import axil_pkg::*;

    logic                   ARVALID;
    logic                   ARREADY;
    logic [ADDR_W-1:0]      ARADDR;
    logic [2:0]             ARPROT;
    logic                   RVALID;
    logic                   RREADY;
    logic [AXIL_DATA_W-1:0] RDATA;
    logic [1:0]             RRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axil_rd_addr_decode.sv
// rtl/axil_rd_addr_decode.sv - byte address to register word index with decode/alignment flags
module axil_rd_addr_decode #(
    parameter int ADDR_W   = 12,
    parameter int NUM_REGS = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-3:0] word_idx,
    output logic              decode_err,
    output logic              align_err
);

    // Word index drops the byte lane bits; out-of-range words are undecoded.
    assign word_idx   = addr[ADDR_W-1:2];
    assign decode_err = 32'(word_idx) >= 32'(NUM_REGS);
    assign align_err  = addr[1:0] != 2'b00;

endmodule

// File: rtl/axil_read_ctrl_slave.sv
// rtl/axil_read_ctrl_slave.sv - AXI4-Lite slave read controller in front of a register bank
module axil_read_ctrl_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int NUM_REGS   = 16,
    parameter int RD_LATENCY = 1     // legal range 1..7, fits the 3-bit counter
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    axil_read_ctrl_slave_if.slave  bus,
    output logic                   rd_en,
    output logic [ADDR_W-3:0]      rd_addr,
    input  logic [AXIL_DATA_W-1:0] rd_data
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    rd_state_t              state, state_n;
    logic [2:0]             cnt, cnt_n;
    logic                   arready_q;
    logic                   rvalid_q;
    logic [AXIL_DATA_W-1:0] rdata_q, rdata_n;
    logic [1:0]             rresp_q, rresp_n;
    logic [ADDR_W-3:0]      rd_addr_q, rd_addr_n;

    logic [ADDR_W-3:0]      dec_idx;
    logic                   dec_err;
    logic                   aln_err;
    logic                   ar_hs;

    // Protection attributes carry no meaning for this register bank.
    logic unused_arprot;
    assign unused_arprot = ^bus.ARPROT;

    axil_rd_addr_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .addr       (bus.ARADDR),
        .word_idx   (dec_idx),
        .decode_err (dec_err),
        .align_err  (aln_err)
    );

    // ARREADY is only ever high in IDLE, so this is the accept condition.
    assign ar_hs = bus.ARVALID && arready_q;

    // Next-state, latency countdown and response capture.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        rd_addr_n = rd_addr_q;
        unique case (state)
            IDLE: begin
                if (ar_hs) begin
                    rd_addr_n = dec_idx;
                    if (dec_err) begin
                        rresp_n = RESP_DECERR;
                        rdata_n = '0;
                        state_n = RESP;
                    end else if (aln_err) begin
                        rresp_n = RESP_SLVERR;
                        rdata_n = '0;
                        state_n = RESP;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ: begin
                cnt_n   = LAT;
                state_n = WAIT;
            end
            WAIT: begin
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    rdata_n = rd_data;
                    rresp_n = RESP_OKAY;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (bus.RREADY) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered channel outputs; handshake flags follow the next state.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rd_addr_q <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            arready_q <= (state_n == IDLE);
            rvalid_q  <= (state_n == RESP);
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
            rd_addr_q <= rd_addr_n;
        end
    end

    assign rd_en       = (state == READ);
    assign rd_addr     = rd_addr_q;
    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_read_ctrl_slave.sv
// tb/tb_axil_read_ctrl_slave.sv - self-checking bench for axil_read_ctrl_slave
module tb_axil_read_ctrl_slave;
    import axil_pkg::*;

    localparam int AW = 12;

    logic        clk;
    logic        aresetn;
    logic        arvalid;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        rready;
    int          cur_sel;

    logic [2:0]  o_arready, o_rvalid, o_rd_en;
    logic [31:0] o_rdata   [3];
    logic [1:0]  o_rresp   [3];
    logic [9:0]  o_rd_addr [3];
    logic [31:0] rd_data   [3];
    logic [31:0] bank      [16];

    int n_tests, n_fail;

    typedef struct {
        int          timeout;
        int          rv_cycle;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          n_rden;
        int          rden_cycle;
        logic [9:0]  rden_addr;
        int          unstable;
        int          ar_busy;
        logic        rvalid_after;
        logic        arready_after;
    } obs_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three DUTs with latencies 1, 3, 4; only the selected one sees ARVALID/RREADY.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        axil_read_ctrl_slave_if #(.ADDR_W(AW)) bus ();
        logic [32:0] pipe [8];

        assign bus.ARVALID  = arvalid && (cur_sel == g);
        assign bus.ARADDR   = araddr;
        assign bus.ARPROT   = arprot;
        assign bus.RREADY   = rready && (cur_sel == g);
        assign o_arready[g] = bus.ARREADY;
        assign o_rvalid[g]  = bus.RVALID;
        assign o_rdata[g]   = bus.RDATA;
        assign o_rresp[g]   = bus.RRESP;

        axil_read_ctrl_slave #(
            .ADDR_W     (AW),
            .NUM_REGS   (16),
            .RD_LATENCY (LAT)
        ) u_dut (
            .ACLK    (clk),
            .ARESETn (aresetn),
            .bus     (bus.slave),
            .rd_en   (o_rd_en[g]),
            .rd_addr (o_rd_addr[g]),
            .rd_data (rd_data[g])
        );

        // Register bank: data is valid only exactly LAT cycles after rd_en.
        always @(posedge clk) begin
            for (int k = 7; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= {o_rd_en[g], bank[o_rd_addr[g][3:0]]};
        end
        assign rd_data[g] = pipe[LAT-1][32] ? pipe[LAT-1][31:0] : 32'hBAD0_BAD0;
    end

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 1 : ((sel == 1) ? 3 : 4);
    endfunction

    // Reference: response, data, RVALID cycle and rd_en count from the address alone.
    function automatic void ref_read(input int sel, input logic [11:0] a,
                                     output logic [1:0] resp, output logic [31:0] data,
                                     output int rv, output int nrd);
        int idx = int'(a) / 4;
        if (idx >= 16) begin
            resp = 2'b11; data = 32'h0; rv = 1; nrd = 0;
        end else if (int'(a) % 4 != 0) begin
            resp = 2'b10; data = 32'h0; rv = 1; nrd = 0;
        end else begin
            resp = 2'b00; data = bank[idx]; rv = lat_of(sel) + 2; nrd = 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One read on DUT sel; cycle 0 is the AR handshake cycle. Observations only.
    task automatic do_read(input int sel, input logic [11:0] addr, input int hold,
                           input bit early, output obs_t o);
        int n;
        int guard;
        o.timeout = 0; o.rv_cycle = 0; o.rdata = '0; o.rresp = '0; o.n_rden = 0;
        o.rden_cycle = -1; o.rden_addr = '0; o.unstable = 0; o.ar_busy = 0;
        o.rvalid_after = 1'b0; o.arready_after = 1'b0;
        cur_sel = sel;
        arvalid = 1'b1;
        araddr  = addr;
        arprot  = 3'($urandom);
        rready  = early;
        guard   = 0;
        while (o_arready[sel] !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) begin
            o.timeout = 1;
            arvalid = 1'b0;
            return;
        end
        step();
        arvalid = 1'b0;
        n = 1;
        while (o_rvalid[sel] !== 1'b1 && n < 30) begin
            if (o_rd_en[sel]) begin
                o.n_rden++;
                o.rden_cycle = n;
                o.rden_addr  = o_rd_addr[sel];
            end
            if (o_arready[sel] !== 1'b0) o.ar_busy++;
            step();
            n++;
        end
        if (n >= 30) begin
            o.timeout = 1;
            rready = 1'b0;
            return;
        end
        o.rv_cycle = n;
        o.rdata    = o_rdata[sel];
        o.rresp    = o_rresp[sel];
        for (int i = 0; i < hold && !early; i++) begin
            if (o_rdata[sel] !== o.rdata || o_rresp[sel] !== o.rresp || o_rvalid[sel] !== 1'b1)
                o.unstable++;
            if (o_arready[sel] !== 1'b0) o.ar_busy++;
            if (o_rd_en[sel]) o.n_rden++;
            step();
        end
        rready = 1'b1;
        if (o_rdata[sel] !== o.rdata || o_rresp[sel] !== o.rresp || o_rvalid[sel] !== 1'b1)
            o.unstable++;
        if (o_arready[sel] !== 1'b0) o.ar_busy++;
        step();
        rready = 1'b0;
        o.rvalid_after  = o_rvalid[sel];
        o.arready_after = o_arready[sel];
    endtask

    task automatic test_reset();
        aresetn = 1'b0; arvalid = 1'b1; araddr = 12'h008; arprot = 3'd0; rready = 1'b0; cur_sel = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (o_arready !== 3'b000 || o_rvalid !== 3'b000 || o_rd_en !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: arready=%b rvalid=%b rd_en=%b want 000", i, o_arready, o_rvalid, o_rd_en);
            end
        end
        n_tests++;
        if (o_rdata[0] !== 32'h0 || o_rresp[0] !== 2'b00 || o_rd_addr[0] !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_regs: rdata=%h rresp=%b rd_addr=%h want 0", o_rdata[0], o_rresp[0], o_rd_addr[0]);
        end
        arvalid = 1'b0;
        aresetn = 1'b1;
        step();
        n_tests++;
        if (o_arready !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release: arready=%b want 111", o_arready);
        end
    endtask

    task automatic test_aligned_read();
        obs_t o;
        bank[2] = 32'hDEAD_BEEF;
        do_read(0, 12'h008, 0, 1'b1, o);
        n_tests++;
        if (o.timeout != 0) begin n_fail++; $display("FAIL aligned_timeout: got %0d want 0", o.timeout); end
        n_tests++;
        if (o.rden_cycle != 1 || o.rden_addr !== 10'd2 || o.n_rden != 1) begin
            n_fail++;
            $display("FAIL aligned_rd_en: cyc=%0d addr=%0d cnt=%0d want 1/2/1", o.rden_cycle, o.rden_addr, o.n_rden);
        end
        n_tests++;
        if (o.rv_cycle != 3) begin n_fail++; $display("FAIL aligned_rvalid_cycle: got %0d want 3", o.rv_cycle); end
        n_tests++;
        if (o.rdata !== 32'hDEAD_BEEF || o.rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL aligned_data: got %h/%b want deadbeef/00", o.rdata, o.rresp);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        bank[1] = 32'h1234_5678;
        do_read(1, 12'h004, 5, 1'b0, o);
        n_tests++;
        if (o.timeout != 0 || o.rv_cycle != 5) begin
            n_fail++;
            $display("FAIL bp_rvalid_cycle: got %0d (timeout %0d) want 5", o.rv_cycle, o.timeout);
        end
        n_tests++;
        if (o.rdata !== 32'h1234_5678 || o.rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_data: got %h/%b want 12345678/00", o.rdata, o.rresp);
        end
        n_tests++;
        if (o.unstable != 0 || o.ar_busy != 0) begin
            n_fail++;
            $display("FAIL bp_hold: unstable=%0d arready_busy=%0d want 0/0", o.unstable, o.ar_busy);
        end
        n_tests++;
        if (o.rvalid_after !== 1'b0 || o.arready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after: rvalid=%b arready=%b want 0/1", o.rvalid_after, o.arready_after);
        end
    endtask

    task automatic test_errors();
        obs_t       o;
        logic [11:0] addrs [3];
        logic [1:0]  exp   [3];
        addrs[0] = 12'h040; exp[0] = 2'b11;
        addrs[1] = 12'h006; exp[1] = 2'b10;
        addrs[2] = 12'h042; exp[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            do_read(0, addrs[i], 1, 1'b0, o);
            n_tests++;
            if (o.timeout != 0 || o.rresp !== exp[i] || o.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL err_resp addr=%h: got %b/%h (timeout %0d) want %b/0", addrs[i], o.rresp, o.rdata, o.timeout, exp[i]);
            end
            n_tests++;
            if (o.rv_cycle != 1 || o.n_rden != 0) begin
                n_fail++;
                $display("FAIL err_timing addr=%h: rvalid_cyc=%0d rd_en=%0d want 1/0", addrs[i], o.rv_cycle, o.n_rden);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          hs2, nb, rden;
        int          rv_cyc  [2];
        logic [31:0] rv_data [2];
        int          guard;
        int          rv1, rv2;
        bank[0] = $urandom;
        bank[3] = $urandom;
        cur_sel = 0; rready = 1'b1; arvalid = 1'b1; araddr = 12'h000;
        hs2 = -1; nb = 0; rden = 0; rv_cyc[0] = -1; rv_cyc[1] = -1; rv_data[0] = '0; rv_data[1] = '0;
        guard = 0;
        while (o_arready[0] !== 1'b1 && guard < 20) begin step(); guard++; end
        step();
        araddr = 12'h00C;
        for (int n = 1; n < 16; n++) begin
            if (o_rd_en[0]) rden++;
            if (o_rvalid[0]) begin
                if (nb < 2) begin rv_cyc[nb] = n; rv_data[nb] = o_rdata[0]; end
                nb++;
            end
            if (o_arready[0] && arvalid) hs2 = n;
            step();
            if (hs2 == n) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        rv1 = lat_of(0) + 2;
        rv2 = rv1 + 1 + lat_of(0) + 2;
        n_tests++;
        if (nb != 2 || rden != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: beats=%0d rd_en=%0d want 2/2", nb, rden);
        end
        n_tests++;
        if (rv_cyc[0] != rv1 || hs2 != rv1 + 1 || rv_cyc[1] != rv2) begin
            n_fail++;
            $display("FAIL b2b_timing: rv1=%0d hs2=%0d rv2=%0d want %0d/%0d/%0d", rv_cyc[0], hs2, rv_cyc[1], rv1, rv1 + 1, rv2);
        end
        n_tests++;
        if (rv_data[0] !== bank[0] || rv_data[1] !== bank[3]) begin
            n_fail++;
            $display("FAIL b2b_data: got %h/%h want %h/%h", rv_data[0], rv_data[1], bank[0], bank[3]);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        int   seen, rdn, guard;
        cur_sel = 2; araddr = 12'h010; arvalid = 1'b1; rready = 1'b1;
        seen = 0; rdn = 0; guard = 0;
        while (o_arready[2] !== 1'b1 && guard < 20) begin step(); guard++; end
        step();
        arvalid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            if (o_rvalid[2]) seen++;
            if (o_rd_en[2]) rdn++;
            if (n == 3) aresetn = 1'b0;
            step();
        end
        n_tests++;
        if (o_rvalid[2] !== 1'b0 || o_arready[2] !== 1'b0 || o_rd_en[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rvalid=%b arready=%b rd_en=%b want 0/0/0", o_rvalid[2], o_arready[2], o_rd_en[2]);
        end
        step();
        aresetn = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (o_rvalid[2]) seen++;
            step();
        end
        rready = 1'b0;
        n_tests++;
        if (seen != 0 || rdn != 1) begin
            n_fail++;
            $display("FAIL midrst_no_beat: rvalid_seen=%0d rd_en=%0d want 0/1", seen, rdn);
        end
        bank[4] = 32'hA5A5_0F0F;
        do_read(2, 12'h010, 2, 1'b0, o);
        n_tests++;
        if (o.timeout != 0 || o.rresp !== 2'b00 || o.rdata !== 32'hA5A5_0F0F || o.rv_cycle != 6) begin
            n_fail++;
            $display("FAIL midrst_next: got %b/%h cyc=%0d (timeout %0d) want 00/a5a50f0f cyc=6", o.rresp, o.rdata, o.rv_cycle, o.timeout);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        int          sel, hold, rv, nrd;
        bit          early;
        logic [11:0] a;
        logic [1:0]  eresp;
        logic [31:0] edata;
        for (int it = 0; it < 40; it++) begin
            sel   = $urandom_range(0, 2);
            hold  = $urandom_range(0, 4);
            early = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) a = 12'($urandom_range(0, 15) * 4);
            else                           a = 12'($urandom_range(0, 4095));
            bank[$urandom_range(0, 15)] = $urandom;
            do_read(sel, a, hold, early, o);
            ref_read(sel, a, eresp, edata, rv, nrd);
            n_tests++;
            if (o.timeout != 0 || o.rresp !== eresp || o.rdata !== edata) begin
                n_fail++;
                $display("FAIL rand_resp it=%0d dut=%0d addr=%h: got %b/%h (timeout %0d) want %b/%h", it, sel, a, o.rresp, o.rdata, o.timeout, eresp, edata);
            end
            n_tests++;
            if (o.rv_cycle != rv || o.n_rden != nrd || (nrd == 1 && o.rden_addr !== a[11:2])) begin
                n_fail++;
                $display("FAIL rand_timing it=%0d dut=%0d addr=%h: rv=%0d rd_en=%0d rd_addr=%h want %0d/%0d/%h", it, sel, a, o.rv_cycle, o.n_rden, o.rden_addr, rv, nrd, a[11:2]);
            end
            n_tests++;
            if (o.unstable != 0 || o.ar_busy != 0 || o.rvalid_after !== 1'b0 || o.arready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_handshake it=%0d: unstable=%0d busy=%0d rvalid=%b arready=%b want 0/0/0/1", it, o.unstable, o.ar_busy, o.rvalid_after, o.arready_after);
            end
            for (int g = 0; g < $urandom_range(0, 2); g++) step();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) bank[i] = $urandom;
        test_reset();
        test_aligned_read();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
